// File: rtl/twice_hls_deadlock_persist_monitor.sv
// twice_hls_deadlock_persist_monitor: persistence-filtered HLS deadlock monitor with sticky/first-offender/event diagnostics
module twice_hls_deadlock_persist_monitor #(
  parameter  int NUM_AXIS  = 2,
  parameter  int NUM_INST  = 1,
  parameter  int THRESHOLD = 16,
  parameter  int CNT_W     = 16,
  localparam int IW        = $clog2(NUM_AXIS + 1),
  localparam int II        = (NUM_INST > 0) ? NUM_INST : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_AXIS-1:0] axis_block_sigs,
  input  logic [II-1:0]       inst_idle_sigs,
  input  logic [II-1:0]       inst_block_sigs,
  input  logic                clear,
  output logic                block,
  output logic                block_sticky,
  output logic                first_valid,
  output logic [IW-1:0]       first_chan,
  output logic [CNT_W-1:0]    block_events
);
  localparam int RW = $clog2(THRESHOLD + 1);
  typedef enum logic [1:0] {IDLE, WATCH, BLOCKED} state_t;
  state_t state_q, state_d;
  logic [RW-1:0] run_q, run_d;
  logic [IW-1:0] cand, cand_q, cand_d, fc_q, fc_d, fc_base;
  logic [CNT_W-1:0] ev_q, ev_d, ev_base;
  logic sticky_q, sticky_d, fv_q, fv_d, fv_base;
  logic sub_all, cur, enter;
  if (NUM_INST > 0) begin : g_sub
    assign sub_all = (&(inst_idle_sigs | inst_block_sigs)) & (|inst_block_sigs);
  end else begin : g_nosub
    assign sub_all = 1'b0;
  end
  assign cur = (|axis_block_sigs) | sub_all;
  // Scan downward so the lowest asserted channel wins; NUM_AXIS tags a sub-instance source.
  always_comb begin
    cand = IW'(NUM_AXIS);
    for (int i = NUM_AXIS - 1; i >= 0; i--)
      if (axis_block_sigs[i]) cand = IW'(i);
  end
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    cand_d  = cand_q;
    enter   = 1'b0;
    case (state_q)
      IDLE: if (cur) begin
        cand_d  = cand;
        run_d   = RW'(1);
        state_d = (THRESHOLD == 1) ? BLOCKED : WATCH;
        enter   = (THRESHOLD == 1);
      end
      WATCH: if (!cur) begin
        state_d = IDLE;
        run_d   = '0;
      end else if (run_q == RW'(THRESHOLD - 1)) begin
        state_d = BLOCKED;
        enter   = 1'b1;
      end else begin
        run_d = run_q + RW'(1);
      end
      BLOCKED: if (!cur) begin
        state_d = IDLE;
        run_d   = '0;
      end
      default: begin
        state_d = IDLE;
        run_d   = '0;
      end
    endcase
  end
  // Clear is applied first so a coincident BLOCKED entry re-populates the diagnostics.
  always_comb begin
    sticky_d = 1'b0;
    sticky_d = clear ? 1'b0 : sticky_q;
    fv_base  = clear ? 1'b0 : fv_q;
    fc_base  = clear ? '0 : fc_q;
    ev_base  = clear ? '0 : ev_q;
    sticky_d = sticky_d | enter;
    fv_d     = fv_base | enter;
    ev_d     = (enter && ev_base != '1) ? ev_base + CNT_W'(1) : ev_base;
    fc_d     = (enter && !fv_base) ? ((state_q == IDLE) ? cand : cand_q) : fc_base;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      run_q    <= '0;
      cand_q   <= '0;
      sticky_q <= 1'b0;
      fv_q     <= 1'b0;
      fc_q     <= '0;
      ev_q     <= '0;
    end else begin
      state_q  <= state_d;
      run_q    <= run_d;
      cand_q   <= cand_d;
      sticky_q <= sticky_d;
      fv_q     <= fv_d;
      fc_q     <= fc_d;
      ev_q     <= ev_d;
    end
  end
  assign block        = (state_q == BLOCKED);
  assign block_sticky = sticky_q;
  assign first_valid  = fv_q;
  assign first_chan   = fc_q;
  assign block_events = ev_q;
endmodule
